// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single-read-port instruction ROM between fetch (I) and data (D).
// Optional build macro: ROM_ARB_ALIGN_CHECK_EN adds registered misaligned-address flags on rerr_*.
module rom_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              gnt_i,
   output logic              rvalid_i,
   output logic [31:0]       rdata_i,
   output logic              rerr_i,
   input  logic              req_d,
   input  logic [ADDR_W-1:0] addr_d,
   output logic              gnt_d,
   output logic              rvalid_d,
   output logic [31:0]       rdata_d,
   output logic              rerr_d,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [31:0]       rom_data,
   output logic              starved
);

   // Owner encoding doubles as the response valids: bit 0 = I, bit 1 = D.
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   owner_t            owner;
   logic [ADDR_W-1:0] held_addr;
   logic [3:0]        starve_cnt;

   function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                              input logic       req,
                                              input logic       gnt);
      if (!req || gnt) return 4'd0;
      if (cnt >= LIMIT) return LIMIT;
      return cnt + 4'd1;
   endfunction

   assign starved = (starve_cnt == LIMIT);

   // Grants are held low during reset so rom_address falls back to the cleared hold register.
   assign gnt_i = reset_n & req_i & (~req_d | starved);
   assign gnt_d = reset_n & req_d & ~gnt_i;

   always_comb begin
      rom_address = held_addr;
      if (gnt_i) begin
         rom_address = addr_i;
      end else if (gnt_d) begin
         rom_address = addr_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner      <= OWN_NONE;
         held_addr  <= '0;
         starve_cnt <= 4'd0;
      end else begin
         if (gnt_i) begin
            owner <= OWN_I;
         end else if (gnt_d) begin
            owner <= OWN_D;
         end else begin
            owner <= OWN_NONE;
         end
         if (gnt_i || gnt_d) begin
            held_addr <= rom_address;
         end
         starve_cnt <= starve_next(starve_cnt, req_i, gnt_i);
      end
   end

   assign rvalid_i = owner[0];
   assign rvalid_d = owner[1];
   assign rdata_i  = rom_data;
   assign rdata_d  = rom_data;

`ifdef ROM_ARB_ALIGN_CHECK_EN
   logic mis_i;
   logic mis_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mis_i <= 1'b0;
         mis_d <= 1'b0;
      end else begin
         mis_i <= gnt_i & (addr_i[1:0] != 2'b00);
         mis_d <= gnt_d & (addr_d[1:0] != 2'b00);
      end
   end

   assign rerr_i = mis_i;
   assign rerr_d = mis_d;
`else
   assign rerr_i = 1'b0;
   assign rerr_d = 1'b0;
`endif

endmodule
